// File: rtl/trig_pkg.sv
// Shared types for the trig lookup scheduler: angle/fp44 types, request ops,
// FSM states and the in-flight lookup descriptor.
package trig_pkg;

  typedef logic [10:0] angle_t;
  typedef logic [43:0] fp44_t;

  typedef enum logic [1:0] {
    OP_SIN    = 2'd0,
    OP_COS    = 2'd1,
    OP_SINCOS = 2'd2
  } trig_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SECOND = 2'd2
  } sched_state_e;

  localparam angle_t ANGLE_QUARTER = 11'h200;
  localparam int     ID_W          = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    trig_op_e        op;
    logic            half;   // 0 = first (sin) lookup, 1 = second (cos) half of SINCOS
  } pipe_entry_t;

  // The unused encoding 2'b11 behaves as SIN.
  function automatic trig_op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_COS;
      2'b10:   return OP_SINCOS;
      default: return OP_SIN;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_id_o,
  output logic          any_o
);

  logic [PW-1:0] idx;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      // ptr_i is always < N, so a single wrap subtraction suffices
      if (int'(ptr_i) + i >= N) idx = PW'(int'(ptr_i) + i - N);
      else                      idx = PW'(int'(ptr_i) + i);
      if (!any_o && req_i[idx]) begin
        any_o       = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o  = idx;
      end
    end
  end

endmodule

// File: rtl/trig_sched.sv
// Shares one registered sine LUT between NREQ requesters; cos = sin(angle + quarter),
// SINCOS is two back-to-back lookups returned as a single response.
module trig_sched
  import trig_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LUT_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*11-1:0] req_angle,
  input  logic [NREQ*2-1:0] req_op,
  output logic [10:0]       lut_angle,
  input  logic [43:0]       lut_val,
  output logic [NREQ-1:0]   resp_valid,
  output logic [43:0]       resp_sin,
  output logic [43:0]       resp_cos,
  output logic [1:0]        dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req_valid[i] && req_ready[i] in the same cycle. Responses have no
  // backpressure; resp_valid[id] is a single-cycle pulse.
  sched_state_e  state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  angle_t        lut_angle_q, lut_angle_d;
  pipe_entry_t   pipe_q [LUT_LAT+1];
  pipe_entry_t   issue_d, exit_e;
  fp44_t         hold_q, resp_sin_q, resp_cos_q;
  logic [ID_W-1:0] lock_id_q;
  angle_t        lock_angle_q;
  logic [NREQ-1:0] resp_valid_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_id;
  logic            any_valid, hs;
  angle_t          g_angle;
  trig_op_e        g_op;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .any_o      (any_valid)
  );

  assign g_angle = req_angle[int'(grant_id)*11 +: 11];
  assign g_op    = decode_op(req_op[int'(grant_id)*2 +: 2]);
  assign hs      = reset_n && (state_q != ST_SECOND) && any_valid;
  assign exit_e  = pipe_q[LUT_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SECOND: state_d = ST_ISSUE;
      default: begin
        if (hs) state_d = (g_op == OP_SINCOS) ? ST_SECOND : ST_ISSUE;
        else    state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready   = '0;
    issue_d     = '0;
    lut_angle_d = lut_angle_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == ST_SECOND) begin
      lut_angle_d = lock_angle_q;
      issue_d     = '{valid: 1'b1, id: lock_id_q, op: OP_SINCOS, half: 1'b1};
    end else if (hs) begin
      req_ready   = grant;
      lut_angle_d = (g_op == OP_COS) ? g_angle + ANGLE_QUARTER : g_angle;
      issue_d     = '{valid: 1'b1, id: ID_W'(grant_id), op: g_op, half: 1'b0};
      rr_ptr_d    = (grant_id == PW'(NREQ-1)) ? '0 : grant_id + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      lut_angle_q  <= '0;
      for (int s = 0; s <= LUT_LAT; s++) pipe_q[s] <= '0;
      hold_q       <= '0;
      lock_id_q    <= '0;
      lock_angle_q <= '0;
      resp_valid_q <= '0;
      resp_sin_q   <= '0;
      resp_cos_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lut_angle_q <= lut_angle_d;
      pipe_q[0]   <= issue_d;
      for (int s = 1; s <= LUT_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      if (hs && g_op == OP_SINCOS) begin
        lock_id_q    <= ID_W'(grant_id);
        lock_angle_q <= g_angle + ANGLE_QUARTER;
      end
      resp_valid_q <= '0;
      // lut_val belongs to the entry leaving the last pipeline stage
      if (exit_e.valid) begin
        case (exit_e.op)
          OP_COS: begin
            resp_sin_q   <= '0;
            resp_cos_q   <= lut_val;
            resp_valid_q <= NREQ'(1) << exit_e.id;
          end
          OP_SINCOS: begin
            if (!exit_e.half) begin
              hold_q <= lut_val;
            end else begin
              resp_sin_q   <= hold_q;
              resp_cos_q   <= lut_val;
              resp_valid_q <= NREQ'(1) << exit_e.id;
            end
          end
          default: begin
            resp_sin_q   <= lut_val;
            resp_cos_q   <= '0;
            resp_valid_q <= NREQ'(1) << exit_e.id;
          end
        endcase
      end
    end
  end

  assign lut_angle  = lut_angle_q;
  assign resp_valid = resp_valid_q;
  assign resp_sin   = resp_sin_q;
  assign resp_cos   = resp_cos_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched with a registered sine-LUT model and an in-order
// response scoreboard.
module tb_trig_sched;

  localparam int NREQ = 4;
  localparam int W    = 3 + 44 + 44;

  localparam logic [43:0] ONE   = 44'h010_0000_0000;
  localparam logic [43:0] M_ONE = 44'hFF0_0000_0000;
  localparam logic [43:0] S45   = 44'h00B_504F_333F;
  localparam logic [43:0] M_S45 = 44'hFF4_AFB0_CCC1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid;
  logic [NREQ*11-1:0]  req_angle;
  logic [NREQ*2-1:0]   req_op;
  logic [10:0]         lut_angle;
  logic [43:0]         lut_val, resp_sin, resp_cos;
  logic [1:0]          dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int last_resp_cyc = -1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  trig_sched #(.NREQ(NREQ), .LUT_LAT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .req_op     (req_op),
    .lut_angle  (lut_angle),
    .lut_val    (lut_val),
    .resp_valid (resp_valid),
    .resp_sin   (resp_sin),
    .resp_cos   (resp_cos),
    .dbg_state  (dbg_state)
  );

  // clock / reset and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [43:0] sin_model(input logic [10:0] a);
    case (a)
      11'h000, 11'h400: return 44'h0;
      11'h100, 11'h300: return S45;
      11'h200:          return ONE;
      11'h500, 11'h700: return M_S45;
      11'h600:          return M_ONE;
      default:          return {33'd0, a};
    endcase
  endfunction

  // registered TrigLUT model, one cycle latency
  always @(posedge clk) lut_val <= sin_model(lut_angle);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int id, input logic [1:0] op, input logic [10:0] ang);
    req_valid[id]          = 1'b1;
    req_op[id*2 +: 2]      = op;
    req_angle[id*11 +: 11] = ang;
  endtask

  task automatic clr_req(input int id);
    req_valid[id] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input int id, input logic [43:0] s, input logic [43:0] c);
    logic [2:0] id3;
    id3 = 3'(id);
    exp_q.push_back({id3, s, c});
  endtask

  task automatic wait_resp(input int id, input int start, output int n);
    n = start;
    while (n < start + 12) begin
      @(negedge clk);
      n++;
      if (resp_valid[id]) break;
    end
  endtask

  // scoreboard: every response must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n && resp_valid != '0) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_id",  64'(resp_valid), 64'd1 << mon_e[90:88]);
        check("resp_sin", 64'(resp_sin),   64'(mon_e[87:44]));
        check("resp_cos", 64'(resp_cos),   64'(mon_e[43:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    int rc0;
    int seen;
    req_valid = '0;
    req_op    = '0;
    req_angle = '0;
    reset_n   = 1'b0;

    // reset state, with a request pending so req_ready gating is observable
    req_valid = 4'b0010;
    @(negedge clk);
    check("rst_lut_angle",  64'(lut_angle),  64'd0);
    check("rst_req_ready",  64'(req_ready),  64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_sin",   64'(resp_sin),   64'd0);
    check("rst_resp_cos",   64'(resp_cos),   64'd0);
    check("rst_state",      64'(dbg_state),  64'd0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // single SIN on req 0, angle quarter turn
    step();
    set_req(0, 2'b00, 11'h200);
    @(negedge clk);
    check("sin_ready", 64'(req_ready), 64'b0001);
    expect_resp(0, ONE, 44'h0);
    @(posedge clk); #1;
    clr_req(0);
    wait_resp(0, 0, n);
    check("sin_latency", 64'(n), 64'd3);

    // COS on req 1 with angle wrap
    step();
    set_req(1, 2'b01, 11'h700);
    @(negedge clk);
    check("cos_ready", 64'(req_ready), 64'b0010);
    expect_resp(1, 44'h0, S45);
    @(posedge clk); #1;
    clr_req(1);
    @(negedge clk);
    check("cos_lut_angle", 64'(lut_angle), 64'h100);
    wait_resp(1, 1, n);
    check("cos_latency", 64'(n), 64'd3);

    // SINCOS on req 2, request left asserted through SECOND
    step();
    set_req(2, 2'b10, 11'h600);
    @(negedge clk);
    check("sc_ready", 64'(req_ready), 64'b0100);
    expect_resp(2, M_ONE, 44'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sc_second_ready", 64'(req_ready), 64'd0);
    check("sc_second_state", 64'(dbg_state), 64'd2);
    check("sc_lut_sin",      64'(lut_angle), 64'h600);
    @(posedge clk); #1;
    clr_req(2);
    @(negedge clk);
    check("sc_lut_cos",    64'(lut_angle), 64'h000);
    check("sc_issue_state", 64'(dbg_state), 64'd1);
    wait_resp(2, 2, n);
    check("sc_latency", 64'(n), 64'd4);

    // SINCOS on req 0 with SIN pending on req 1 (rr_ptr is 3 here)
    step();
    set_req(0, 2'b10, 11'h080);
    set_req(1, 2'b00, 11'h500);
    @(negedge clk);
    check("pend_ready0", 64'(req_ready), 64'b0001);
    expect_resp(0, 44'h080, 44'h280);
    @(posedge clk); #1;
    clr_req(0);
    @(negedge clk);
    check("pend_second_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("pend_ready1", 64'(req_ready), 64'b0010);
    expect_resp(1, M_S45, 44'h0);
    @(posedge clk); #1;
    clr_req(1);
    wait_resp(0, 2, n);
    check("pend_lat0", 64'(n), 64'd4);
    wait_resp(1, 4, n);
    check("pend_lat1", 64'(n), 64'd5);

    // reset with a SINCOS and a SIN in flight (three lookups)
    step();
    set_req(2, 2'b10, 11'h0F0);
    set_req(3, 2'b00, 11'h123);
    @(negedge clk);
    check("fl_ready2", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    clr_req(2);
    @(posedge clk);
    @(negedge clk);
    check("fl_ready3", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    clr_req(3);
    check("fl_lut_before", 64'(lut_angle), 64'h123);
    req_valid[0] = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_lut_angle",  64'(lut_angle),  64'd0);
    check("mid_rst_req_ready",  64'(req_ready),  64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_resp_sin",   64'(resp_sin),   64'd0);
    check("mid_rst_resp_cos",   64'(resp_cos),   64'd0);
    check("mid_rst_state",      64'(dbg_state),  64'd0);
    @(negedge clk);
    @(negedge clk);
    clr_req(0);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid != '0) seen++;
    end
    check("dropped_resp", 64'(seen), 64'd0);

    // all four requesters streaming SIN; req 3 uses op 2'b11
    step();
    rc0 = resp_cnt;
    c0  = 0;
    set_req(0, 2'b00, 11'h010);
    set_req(1, 2'b00, 11'h020);
    set_req(2, 2'b00, 11'h030);
    set_req(3, 2'b11, 11'h040);
    for (int k = 0; k < 5; k++) begin
      logic [10:0] ang;
      @(negedge clk);
      if (k == 0) c0 = cyc;
      check("rr_grant", 64'(req_ready), 64'd1 << (k % 4));
      ang = 11'(((k % 4) + 1) * 16);
      expect_resp(k % 4, {33'd0, ang}, 44'h0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (8) @(negedge clk);
    check("rr_resp_count", 64'(resp_cnt - rc0), 64'd5);
    check("rr_last_resp",  64'(last_resp_cyc),  64'(c0 + 7));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_sched.md
Name: trig_sched

Overview:
- Schedules and shares the single TrigLUT sine lookup between NREQ requesters, e.g. ray-direction and wall-projection units.
- Each request asks for sin, cos, or both of one angle.
- cos is computed as sin(angle + quarter turn).
- SINCOS requests are issued as two back-to-back lookups and returned together.
- Sits between the requesters and the TrigLUT instance. It owns the LUT address input and consumes the LUT output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LUT_LAT, 1, cycles from lut_angle presented to lut_val valid (TrigLUT ROM is registered).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept. A handshake occurs when req_valid[i] and req_ready[i] are both high.
- req_angle  in  NREQ*11  angle per requester (angle type, 11'h800 = full turn).
- req_op  in  NREQ*2  00=SIN, 01=COS, 10=SINCOS, 11 treated as SIN.
- lut_angle  out  11  registered angle to TrigLUT inval.
- lut_val  in  44  TrigLUT outval (fp44: 8 integer bits, 36 fraction bits).
- resp_valid  out  NREQ  one-cycle pulse to the owning requester.
- resp_sin  out  44  sin result (SIN, SINCOS). 0 for COS.
- resp_cos  out  44  cos result (COS, SINCOS). 0 for SIN.

Behaviour:
- Reset (async, reset_n low) forces:
  - state IDLE, rr_ptr=0;
  - all pipeline valid bits 0, hold register 0;
  - lut_angle=0, req_ready=0, resp_valid=0, resp_sin=0, resp_cos=0.
- Reset mid-operation discards in-flight lookups and any held sin half. No response is produced for them.
- FSM states:
  - IDLE/ISSUE: the arbiter is active. req_ready is combinational: exactly one bit high, for the round-robin winner among req_valid starting at rr_ptr. All low if none valid.
  - SECOND: all req_ready low. Issues the cos half of the locked SINCOS request, then returns to ISSUE.
- ISSUE on handshake by requester g:
  - rr_ptr <= (g+1) mod NREQ.
  - lut_angle <= angle for SIN/SINCOS, or angle+11'h200 (11-bit wrap) for COS.
  - Pipeline entry {valid, id=g, op, half=first} enters stage 0.
  - If op is SINCOS: latch id and angle+11'h200, go to SECOND.
- SECOND: lut_angle <= latched cos angle, pipeline entry half=second.
- Pipeline depth is 1+LUT_LAT. lut_val is sampled when an entry exits.
- On exit, by entry type:
  - SIN/COS: register result into resp_sin or resp_cos, other field 0, and pulse resp_valid[id] next cycle.
  - SINCOS first half: store lut_val in hold register, no response.
  - SINCOS second half: resp_sin <= hold, resp_cos <= lut_val, pulse resp_valid[id].
- Latency from handshake to resp_valid high: 2+LUT_LAT cycles (3 at default) for SIN/COS, 3+LUT_LAT for SINCOS.
- Throughput: one lookup per cycle; SINCOS costs two issue slots.
- Responses are in issue order, at most one per cycle. There is no response backpressure, so requesters must accept.
- lut_angle holds its last value when idle. Result correctness never depends on idle lut_angle.
- A requester deasserting req_valid without a handshake is legal. It has no effect.

Decomposition:
- Shared package trig_pkg:
  - trig_op_e (SIN, COS, SINCOS);
  - ANGLE_QUARTER=11'h200;
  - the pipeline entry struct {valid, id, op, half}.
- Reuse the angle and fp44 types from structs.sv.
- One sub-module, rr_arbiter (NREQ-wide, combinational grant from req and pointer). FSM, pipeline and response logic stay in trig_sched.

Test Plan:
- Single SIN on req 0, angle 11'h200, bench TrigLUT model -> resp_valid[0] exactly 3 cycles after handshake, resp_sin=44'h010_0000_0000 (1.0), resp_cos=0.
- COS on req 1, angle 11'h700 -> lut_angle=11'h100 (wrap). resp_cos equals the model's sin(11'h100), resp_sin=0.
- SINCOS on req 2, angle 11'h600 -> req_ready all low the following cycle. 4 cycles later resp_sin=-1.0 (44'hFF0_0000_0000) and resp_cos=sin(0)=0.
- All 4 requesters hold SIN continuously -> grants 0,1,2,3,0 in consecutive cycles, and responses return in the same order one per cycle.
- SINCOS on req 0 with req 1 SIN pending -> req 1 is granted on the cycle after SECOND. Response order is req 0 then req 1, separated by one cycle.
- reset_n pulsed low while 3 lookups are in flight -> every output is 0 immediately, no resp_valid is produced for the dropped requests, and rr_ptr restarts at 0.
